// File: rtl/bp_pkg.sv
// Shared types and default sizing for the branch-prediction fetch pipeline.
package bp_pkg;

    localparam int BTB_DEPTH_DEFAULT = 6;
    localparam int HASH_W_DEFAULT    = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } bp_meta_t;

endpackage

// File: rtl/bp_fetch_pipe_if.sv
// Bus between the fetch predictor pipeline and the core: F lookup, M resolution, stats.
interface bp_fetch_pipe_if #(
    parameter int HASH_W = bp_pkg::HASH_W_DEFAULT
);
    logic [31:0]       pcF;
    logic              pcsrcPF;
    logic              stallD;
    logic              flushD;
    logic              stallE;
    logic              flushE;
    logic              flushM;
    logic              branchM;
    logic              pcsrcM;
    logic [31:0]       targetM;
    logic [31:0]       pcM;
    logic [HASH_W-1:0] hashed_pcF;
    logic [HASH_W-1:0] hashed_pcM;
    logic              btb_hitF;
    logic              pred_takenF;
    logic [31:0]       pred_targetF;
    logic              pcsrcPM;
    logic              mispredictM;
    logic [31:0]       redirect_pcM;
    logic [31:0]       br_cnt;
    logic [31:0]       miss_cnt;

    modport master (
        output pcF, pcsrcPF, stallD, flushD, stallE, flushE, flushM,
               branchM, pcsrcM, targetM, pcM,
        input  hashed_pcF, hashed_pcM, btb_hitF, pred_takenF, pred_targetF,
               pcsrcPM, mispredictM, redirect_pcM, br_cnt, miss_cnt
    );

    modport slave (
        input  pcF, pcsrcPF, stallD, flushD, stallE, flushE, flushM,
               branchM, pcsrcM, targetM, pcM,
        output hashed_pcF, hashed_pcM, btb_hitF, pred_takenF, pred_targetF,
               pcsrcPM, mispredictM, redirect_pcM, br_cnt, miss_cnt
    );
endinterface

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: combinational lookup, write on resolved taken branch.
module bp_btb
    import bp_pkg::*;
#(
    parameter int BTB_DEPTH = BTB_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lookupPc,
    output logic        hit,
    output logic [31:0] target,
    input  logic        wrEn,
    input  logic [31:0] wrPc,
    input  logic [31:0] wrTarget
);
    localparam int ENTRIES = 1 << BTB_DEPTH;
    localparam int TAG_W   = 30 - BTB_DEPTH;

    logic [ENTRIES-1:0]   valid;
    logic [TAG_W-1:0]     tagMem [ENTRIES];
    logic [29:0]          tgtMem [ENTRIES];
    logic [BTB_DEPTH-1:0] rdIdx;
    logic [BTB_DEPTH-1:0] wrIdx;
    logic [TAG_W-1:0]     rdTag;
    logic [TAG_W-1:0]     wrTag;
    logic                 unusedLowBits;

    assign rdIdx = lookupPc[BTB_DEPTH+1:2];
    assign rdTag = lookupPc[31:BTB_DEPTH+2];
    assign wrIdx = wrPc[BTB_DEPTH+1:2];
    assign wrTag = wrPc[31:BTB_DEPTH+2];
    // Instruction addresses are word aligned; the byte-offset bits carry no information.
    assign unusedLowBits = ^{lookupPc[1:0], wrPc[1:0], wrTarget[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else if (wrEn) begin
            valid[wrIdx] <= 1'b1;
        end
    end

    // Tags and targets are qualified by valid, so they never need clearing.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            tagMem[wrIdx] <= wrTag;
            tgtMem[wrIdx] <= wrTarget[31:2];
        end
    end

    always_comb begin
        hit    = valid[rdIdx] && (tagMem[rdIdx] == rdTag);
        target = '0;
        if (hit) begin
            target = {tgtMem[rdIdx], 2'b00};
        end
    end
endmodule

// File: rtl/bp_fetch_pipe.sv
// Fetch-side branch prediction: BTB lookup in F, metadata carried to M, mispredict detection and stats.
module bp_fetch_pipe
    import bp_pkg::*;
#(
    parameter int BTB_DEPTH = BTB_DEPTH_DEFAULT,
    parameter int HASH_W    = HASH_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    bp_fetch_pipe_if.slave bus
);
    function automatic logic [31:0] satInc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic        btbHit;
    logic [31:0] btbTarget;
    logic        btbWrEn;
    logic        predTakenF;
    bp_meta_t    meta_p0;
    bp_meta_t    meta_p1;
    bp_meta_t    meta_p2;
    bp_meta_t    meta_p3;
    logic        mispredict;
    logic [31:0] redirectPc;
    logic [31:0] brCnt;
    logic [31:0] missCnt;
    logic        unusedPcM;

    assign btbWrEn = bus.branchM & bus.pcsrcM;

    bp_btb #(
        .BTB_DEPTH (BTB_DEPTH)
    ) uBtb (
        .clk      (clk),
        .rst      (rst),
        .lookupPc (bus.pcF),
        .hit      (btbHit),
        .target   (btbTarget),
        .wrEn     (btbWrEn),
        .wrPc     (bus.pcM),
        .wrTarget (bus.targetM)
    );

    always_comb begin
        predTakenF = btbHit & bus.pcsrcPF;
        meta_p0    = '{pc: bus.pcF, taken: predTakenF, target: btbTarget};
    end

    // F -> D
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             meta_p1 <= '0;
        else if (bus.flushD)  meta_p1 <= '0;
        else if (!bus.stallD) meta_p1 <= meta_p0;
    end

    // D -> E
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             meta_p2 <= '0;
        else if (bus.flushE)  meta_p2 <= '0;
        else if (!bus.stallE) meta_p2 <= meta_p1;
    end

    // E -> M
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)            meta_p3 <= '0;
        else if (bus.flushM) meta_p3 <= '0;
        else                 meta_p3 <= meta_p2;
    end

    // The pipelined PC is kept for debug visibility; M-stage decisions use pcM.
    assign unusedPcM = ^meta_p3.pc;

    always_comb begin
        mispredict = bus.branchM &
                     ((meta_p3.taken ^ bus.pcsrcM) |
                      (bus.pcsrcM & meta_p3.taken & (meta_p3.target != bus.targetM)));
        redirectPc = bus.pcsrcM ? bus.targetM : bus.pcM + 32'd8;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            brCnt   <= '0;
            missCnt <= '0;
        end else begin
            if (bus.branchM) brCnt   <= satInc(brCnt);
            if (mispredict)  missCnt <= satInc(missCnt);
        end
    end

    assign bus.hashed_pcF   = bus.pcF[HASH_W+1:2];
    assign bus.hashed_pcM   = bus.pcM[HASH_W+1:2];
    assign bus.btb_hitF     = btbHit;
    assign bus.pred_takenF  = predTakenF;
    assign bus.pred_targetF = btbTarget;
    assign bus.pcsrcPM      = meta_p3.taken;
    assign bus.mispredictM  = mispredict;
    assign bus.redirect_pcM = redirectPc;
    assign bus.br_cnt       = brCnt;
    assign bus.miss_cnt     = missCnt;
endmodule

// File: tb/tb_bp_fetch_pipe.sv
// Directed bench for bp_fetch_pipe: per-cycle vector table plus stall/flush, saturation and reset sequences.
module tb_bp_fetch_pipe;
    localparam int HASH_W = 3;
    localparam logic [31:0] PA = 32'h0040_0010;
    localparam logic [31:0] PB = 32'h0040_0020;
    localparam logic [31:0] T1 = 32'h0040_0100;
    localparam logic [31:0] T2 = 32'h0040_0200;

    logic clk;
    logic rst;
    int   nChk;
    int   nErr;

    bp_fetch_pipe_if #(.HASH_W(HASH_W)) bus ();

    bp_fetch_pipe #(.BTB_DEPTH(6), .HASH_W(HASH_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pcF;
        logic        pf;
        logic        br;
        logic        sM;
        logic [31:0] pcM;
        logic [31:0] tM;
        logic        eHit;
        logic        eTk;
        logic [31:0] eTg;
        logic        ePm;
        logic        eMis;
        logic [31:0] eRed;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChk++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic setCtl(input logic [4:0] ctl);
        {bus.stallD, bus.flushD, bus.stallE, bus.flushE, bus.flushM} = ctl;
    endtask

    task automatic drive(input logic [31:0] pc, input logic pf, input logic [4:0] ctl);
        @(negedge clk);
        bus.pcF = pc;
        bus.pcsrcPF = pf;
        bus.branchM = 1'b0;
        bus.pcsrcM = 1'b0;
        bus.pcM = '0;
        bus.targetM = '0;
        setCtl(ctl);
        #2;
    endtask

    initial begin
        logic [31:0] pcTmp;
        nChk = 0;
        nErr = 0;
        rst = 1'b0;
        bus.pcF = PA;
        bus.pcsrcPF = 1'b1;
        bus.branchM = 1'b0;
        bus.pcsrcM = 1'b0;
        bus.pcM = '0;
        bus.targetM = '0;
        setCtl(5'b0);

        //       pcF          pf    br    sM    pcM           tM     hit   tk    tgt  pm    mis   redirect
        vt[0]  = '{PA,          1'b1, 1'b0, 1'b0, 32'h0,        32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8};
        vt[1]  = '{PA,          1'b1, 1'b1, 1'b1, PA,           T1,    1'b0, 1'b0, 32'h0, 1'b0, 1'b1, T1};
        vt[2]  = '{PA,          1'b1, 1'b0, 1'b0, 32'h0,        32'h0, 1'b1, 1'b1, T1,    1'b0, 1'b0, 32'h8};
        vt[3]  = '{32'h0,       1'b0, 1'b0, 1'b0, 32'h0,        32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8};
        vt[4]  = '{32'h0,       1'b0, 1'b0, 1'b0, 32'h0,        32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8};
        vt[5]  = '{32'h0,       1'b0, 1'b1, 1'b1, PA,           T2,    1'b0, 1'b0, 32'h0, 1'b1, 1'b1, T2};
        vt[6]  = '{PA,          1'b1, 1'b0, 1'b0, 32'h0,        32'h0, 1'b1, 1'b1, T2,    1'b0, 1'b0, 32'h8};
        vt[7]  = '{32'h0,       1'b0, 1'b0, 1'b0, 32'h0,        32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8};
        vt[8]  = '{32'h0,       1'b0, 1'b0, 1'b0, 32'h0,        32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8};
        vt[9]  = '{32'h0,       1'b0, 1'b1, 1'b1, PA,           T2,    1'b0, 1'b0, 32'h0, 1'b1, 1'b0, T2};
        vt[10] = '{PA,          1'b1, 1'b0, 1'b0, 32'h0,        32'h0, 1'b1, 1'b1, T2,    1'b0, 1'b0, 32'h8};
        vt[11] = '{32'h0040_0110, 1'b1, 1'b0, 1'b0, 32'h0,      32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8};
        vt[12] = '{32'h0,       1'b0, 1'b0, 1'b0, 32'h0,        32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8};
        vt[13] = '{32'h0,       1'b0, 1'b1, 1'b0, PA,           32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_0018};
        vt[14] = '{PA,          1'b0, 1'b0, 1'b0, 32'h0,        32'h0, 1'b1, 1'b0, T2,    1'b0, 1'b0, 32'h8};
        vt[15] = '{32'h0,       1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h4};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("rst_hit", {31'b0, bus.btb_hitF}, 32'h0);
        chk("rst_taken", {31'b0, bus.pred_takenF}, 32'h0);
        chk("rst_pcsrcPM", {31'b0, bus.pcsrcPM}, 32'h0);
        chk("rst_br_cnt", bus.br_cnt, 32'h0);
        chk("rst_miss_cnt", bus.miss_cnt, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.pcF = vt[i].pcF;
            bus.pcsrcPF = vt[i].pf;
            bus.branchM = vt[i].br;
            bus.pcsrcM = vt[i].sM;
            bus.pcM = vt[i].pcM;
            bus.targetM = vt[i].tM;
            #2;
            chk($sformatf("v%0d_hit", i), {31'b0, bus.btb_hitF}, {31'b0, vt[i].eHit});
            chk($sformatf("v%0d_taken", i), {31'b0, bus.pred_takenF}, {31'b0, vt[i].eTk});
            chk($sformatf("v%0d_target", i), bus.pred_targetF, vt[i].eTg);
            chk($sformatf("v%0d_pcsrcPM", i), {31'b0, bus.pcsrcPM}, {31'b0, vt[i].ePm});
            chk($sformatf("v%0d_mispredict", i), {31'b0, bus.mispredictM}, {31'b0, vt[i].eMis});
            chk($sformatf("v%0d_redirect", i), bus.redirect_pcM, vt[i].eRed);
            pcTmp = vt[i].pcF;
            chk($sformatf("v%0d_hashF", i), {29'b0, bus.hashed_pcF}, {29'b0, pcTmp[HASH_W+1:2]});
            pcTmp = vt[i].pcM;
            chk($sformatf("v%0d_hashM", i), {29'b0, bus.hashed_pcM}, {29'b0, pcTmp[HASH_W+1:2]});
        end

        drive(32'h0, 1'b0, 5'b0);
        chk("cnt_br", bus.br_cnt, 32'd4);
        chk("cnt_miss", bus.miss_cnt, 32'd3);

        // flushD wins over stallD
        drive(PA, 1'b1, 5'b0);
        drive(32'h0, 1'b0, 5'b11000);
        drive(32'h0, 1'b0, 5'b0);
        drive(32'h0, 1'b0, 5'b0);
        chk("fd_item_at_M", {31'b0, bus.pcsrcPM}, 32'h1);
        drive(32'h0, 1'b0, 5'b0);
        chk("fd_D_cleared", {31'b0, bus.pcsrcPM}, 32'h0);

        // stallD+stallE for two cycles delays arrival in M by two cycles
        drive(PA, 1'b1, 5'b0);
        drive(32'h0, 1'b0, 5'b10100);
        drive(32'h0, 1'b0, 5'b10100);
        drive(32'h0, 1'b0, 5'b0);
        chk("stall_t3", {31'b0, bus.pcsrcPM}, 32'h0);
        drive(32'h0, 1'b0, 5'b0);
        chk("stall_t4", {31'b0, bus.pcsrcPM}, 32'h0);
        drive(32'h0, 1'b0, 5'b0);
        chk("stall_t5", {31'b0, bus.pcsrcPM}, 32'h1);
        drive(32'h0, 1'b0, 5'b0);
        chk("stall_t6", {31'b0, bus.pcsrcPM}, 32'h0);

        // flushE drops the item moving D -> E
        drive(PA, 1'b1, 5'b0);
        drive(32'h0, 1'b0, 5'b00010);
        drive(32'h0, 1'b0, 5'b0);
        drive(32'h0, 1'b0, 5'b0);
        chk("flushE_drop", {31'b0, bus.pcsrcPM}, 32'h0);

        // flushM drops the item moving E -> M
        drive(PA, 1'b1, 5'b0);
        drive(32'h0, 1'b0, 5'b0);
        drive(32'h0, 1'b0, 5'b00001);
        drive(32'h0, 1'b0, 5'b0);
        chk("flushM_drop", {31'b0, bus.pcsrcPM}, 32'h0);

        // Counter saturation
        @(negedge clk);
        force dut.brCnt = 32'hFFFF_FFFF;
        force dut.missCnt = 32'hFFFF_FFFF;
        #1;
        release dut.brCnt;
        release dut.missCnt;
        bus.branchM = 1'b1;
        bus.pcsrcM = 1'b1;
        bus.pcM = PA;
        bus.targetM = T1;
        #1;
        chk("sat_mispredict", {31'b0, bus.mispredictM}, 32'h1);
        @(negedge clk);
        #2;
        chk("sat_br_cnt", bus.br_cnt, 32'hFFFF_FFFF);
        chk("sat_miss_cnt", bus.miss_cnt, 32'hFFFF_FFFF);

        // Asynchronous reset mid-run, with a BTB write pending on the next edge
        bus.branchM = 1'b1;
        bus.pcsrcM = 1'b1;
        bus.pcM = PB;
        bus.targetM = T1;
        bus.pcF = PA;
        bus.pcsrcPF = 1'b1;
        #1;
        chk("pre_rst_hit", {31'b0, bus.btb_hitF}, 32'h1);
        rst = 1'b0;
        #1;
        chk("async_br_cnt", bus.br_cnt, 32'h0);
        chk("async_miss_cnt", bus.miss_cnt, 32'h0);
        chk("async_hit", {31'b0, bus.btb_hitF}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        bus.branchM = 1'b0;
        bus.pcsrcM = 1'b0;
        bus.pcF = PB;
        #2;
        chk("rst_drop_write", {31'b0, bus.btb_hitF}, 32'h0);
        chk("rst_pcsrcPM_clr", {31'b0, bus.pcsrcPM}, 32'h0);

        $display("Result: errors=%0d of %0d checks", nErr, nChk);
        $finish;
    end
endmodule

// File: doc/bp_fetch_pipe.md
BP_FETCH_PIPE -- requirements
Module: bp_fetch_pipe

Interface
REQ-001 Parameters: BTB_DEPTH, default 6, log2 of BTB entry count. HASH_W, default 3, width of the hashed PC sent to the global predictor.
REQ-002 Reset: one clock, clk; reset is asynchronous and active-low, rst.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-low reset.
REQ-005 pcF  in  32  fetch PC.
REQ-006 pcsrcPF  in  1  direction prediction from the global predictor.
REQ-007 stallD, flushD, stallE, flushE, flushM  in  1 each  pipeline hold/clear controls.
REQ-008 branchM  in  1  branch resolved in M.
REQ-009 pcsrcM  in  1  actual taken in M.
REQ-010 targetM  in  32  actual target in M.
REQ-011 pcM  in  32  PC of the branch in M.
REQ-012 hashed_pcF, hashed_pcM  out  HASH_W  pc[HASH_W+1:2] of the F-stage and M-stage PC.
REQ-013 btb_hitF  out  1  valid BTB entry with matching tag.
REQ-014 pred_takenF  out  1  predicted taken, equal to btb_hitF & pcsrcPF.
REQ-015 pred_targetF  out  32  BTB target, low two bits zero.
REQ-016 pcsrcPM  out  1  pred_takenF carried to M.
REQ-017 mispredictM  out  1  redirect required.
REQ-018 redirect_pcM  out  32  corrected PC.
REQ-019 br_cnt, miss_cnt  out  32 each  statistics counters.

Function
REQ-020 BTB shall be direct-mapped with 2^BTB_DEPTH entries; index = pcF[BTB_DEPTH+1:2]; each entry holds valid, tag = pc[31:BTB_DEPTH+2], and target[31:2].
REQ-021 F lookup shall be combinational: btb_hitF = valid & tag match; pred_targetF = {target, 2'b00}; on a miss, pred_targetF shall be 0.
REQ-022 Metadata {pcF, pred_takenF, pred_targetF} shall advance F→D→E→M, one register per stage; latency F to M is 3 cycles.
REQ-023 Each stage register: flush clears it to zero; otherwise stall holds it; otherwise it loads. Flush has priority over stall. The M register has flushM only.
REQ-024 mispredictM = branchM & ((pcsrcPM ^ pcsrcM) | (pcsrcM & pcsrcPM & (pred_targetM != targetM))).
REQ-025 redirect_pcM = targetM when pcsrcM = 1, else pcM + 8 (delay slot); 32-bit wrap on overflow.
REQ-026 BTB write: on the clock edge where branchM & pcsrcM, the entry at pcM's index shall be written with valid = 1, pcM tag, and targetM[31:2]. Not-taken branches shall not modify the BTB.
REQ-027 Simultaneous F read and M write to the same index: F sees the old contents; no bypass.
REQ-028 br_cnt increments on each cycle with branchM = 1; miss_cnt increments on each cycle with mispredictM = 1; both saturate at 32'hFFFF_FFFF.
REQ-029 hashed_pcM shall be taken from pcM, not from the pipelined PC.

Reset
REQ-030 rst low shall asynchronously clear all BTB valid bits, all stage registers, and both counters; tags and targets need not reset.
REQ-031 After rst deasserts, btb_hitF = 0, pred_takenF = 0, pcsrcPM = 0, and mispredictM = branchM & pcsrcM.
REQ-032 Reset asserted mid-operation shall discard any BTB write pending on that edge.

Structure
REQ-033 BTB_DEPTH and HASH_W defaults, plus the bp_meta_t struct {pc, taken, target}, shall reside in shared package bp_pkg.
REQ-034 BTB storage and lookup shall be a single sub-module, bp_btb; pipeline registers, mispredict logic, and counters remain in bp_fetch_pipe.

Verification
REQ-035 Reset then pcF=0x0040_0010, pcsrcPF=1 -> btb_hitF=0, pred_takenF=0.
REQ-036 branchM=1, pcsrcM=1, pcM=0x0040_0010, targetM=0x0040_0100; next cycle pcF=0x0040_0010, pcsrcPF=1 -> btb_hitF=1, pred_targetF=0x0040_0100, pred_takenF=1.
REQ-037 Predicted taken with target 0x0040_0100 reaches M; actual targetM=0x0040_0200 -> mispredictM=1, redirect_pcM=0x0040_0200.
REQ-038 Predicted taken reaches M with pcsrcM=0, pcM=0x0040_0010 -> mispredictM=1, redirect_pcM=0x0040_0018; BTB entry unchanged.
REQ-039 stallD=1 and flushD=1 in the same cycle -> D register cleared; stallE=1 for 2 cycles -> E metadata held, pcsrcPM delayed by 2 cycles.
REQ-040 Preload br_cnt via forced saturation to 0xFFFF_FFFF, then apply branchM=1 -> br_cnt stays 0xFFFF_FFFF; rst low mid-run -> counters 0 immediately, without waiting for a clock edge.
